lcd_init_ctrl: RTL and testbench

- Sequencer directly downstream of the 8-entry LCD command ROM (3-bit address; 9-bit word {RS, DB[7:0]}; end-of-list flag).
- After power-up it walks the ROM, drives each word onto an HD44780-style parallel bus with correct setup, E-pulse and execution timing, then stops at the ROM end flag.
- Once initialised, it accepts single character/command writes from the servo-status logic over a valid/ready handshake.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_delay_cnt.sv | 40 ++++
 rtl/lcd_init_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lcd_init_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD init/write sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        FETCH,
        SETUP,
        E_HIGH,
        WAIT,
        IDLE
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Same bit layout as the ROM word: [8]=RS, [7:0]=DB.
    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_word_t;

    // Clear and home are the only instructions whose execution time is in
    // the millisecond range; everything else, including data writes, is fast.
    function automatic logic is_long_cmd(input lcd_word_t w);
        return !w.rs && ((w.data == LCD_CMD_CLEAR) || (w.data == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter used for every timed phase of the LCD sequencer.
// Latency: a load of N gives o_done in the (N+1)th cycle after the load edge.
// Backpressure: none; a load always wins over an in-flight count.
//
// Ports: i_clk, i_rst (async, active-high), i_load/i_val (start a count),
//        o_busy (count in flight), o_done (one-cycle pulse at terminal count).
module lcd_delay_cnt #(
    parameter int unsigned CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_val,
    output logic          o_busy,
    output logic          o_done
);

    logic [CW-1:0] r_cnt;
    logic          r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= i_val;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == '0);

endmodule

// File: rtl/lcd_init_ctrl.sv
// HD44780 init sequencer: walks the command ROM after power-up, then serves single user writes.
// Latency: user accept -> E rise in SETUP_CYC+1 cycles; wr_ready returns after E_HIGH + post-E wait.
// Backpressure: wr_ready is high only in IDLE; requests seen elsewhere are dropped, never queued.
//
// Ports: clk, rst (async, active-high); rom_addr/rom_q/rom_rdy (command ROM, combinational read);
//        wr_valid/wr_rs/wr_data/wr_ready (user write handshake); init_done (sticky);
//        lcd_rs/lcd_rw/lcd_e/lcd_db (parallel LCD bus, all registered, lcd_rw tied low).
// Build option: define LCD_FAST_SIM_EN to shrink the power-up and post-E waits for simulation.
// Minimums: PWR_UP_CYC >= 2, SETUP_CYC >= 1, E_HIGH_CYC >= 1, both waits >= 1.
module lcd_init_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned PWR_UP_CYC   = 2_000_000,
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned E_HIGH_CYC   = 25,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] rom_addr,
    input  logic [8:0] rom_q,
    input  logic       rom_rdy,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db
);

`ifdef LCD_FAST_SIM_EN
    localparam int unsigned C_PWR = 20;
    localparam int unsigned C_CMD = 8;
    localparam int unsigned C_CLR = 16;
`else
    localparam int unsigned C_PWR = PWR_UP_CYC;
    localparam int unsigned C_CMD = CMD_WAIT_CYC;
    localparam int unsigned C_CLR = CLR_WAIT_CYC;
`endif

    localparam int unsigned C_MAX_A = (C_PWR > C_CLR) ? C_PWR : C_CLR;
    localparam int unsigned C_MAX_B = (C_CMD > SETUP_CYC) ? C_CMD : SETUP_CYC;
    localparam int unsigned C_MAX_C = (E_HIGH_CYC > C_MAX_B) ? E_HIGH_CYC : C_MAX_B;
    localparam int unsigned C_MAX   = (C_MAX_A > C_MAX_C) ? C_MAX_A : C_MAX_C;
    localparam int unsigned CW      = $clog2(C_MAX + 1);

    // A load of N-1 keeps the loading state for N cycles. Power-up loads one
    // less because its first cycle (counter idle out of reset) is the arming cycle.
    localparam logic [CW-1:0] LD_PWR   = CW'(C_PWR - 2);
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EHIGH = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(C_CMD - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(C_CLR - 1);

    lcd_state_t    r_state;
    logic [2:0]    r_rom_addr;
    logic          r_lcd_e;
    logic          r_lcd_rs;
    logic [7:0]    r_lcd_db;
    logic          r_init_done;
    logic          r_wr_ready;
    logic          r_long_wait;

    lcd_word_t     w_rom_word;
    lcd_word_t     w_wr_word;
    logic          w_accept;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_busy;
    logic          w_done;

    assign w_rom_word = rom_q;
    assign w_wr_word  = {wr_rs, wr_data};
    assign w_accept   = wr_valid && r_wr_ready;

    lcd_delay_cnt #(
        .CW (CW)
    ) u_delay (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_busy (w_busy),
        .o_done (w_done)
    );

    // Counter loads coincide with the state transitions below so that the
    // count runs from the first cycle of the state being entered.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            PWR_WAIT: if (!w_busy) begin
                w_load     = 1'b1;
                w_load_val = LD_PWR;
            end
            FETCH: if (!rom_rdy) begin
                w_load     = 1'b1;
                w_load_val = LD_SETUP;
            end
            SETUP: if (w_done) begin
                w_load     = 1'b1;
                w_load_val = LD_EHIGH;
            end
            E_HIGH: if (w_done) begin
                w_load     = 1'b1;
                w_load_val = r_long_wait ? LD_CLR : LD_CMD;
            end
            IDLE: if (w_accept) begin
                w_load     = 1'b1;
                w_load_val = LD_SETUP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= PWR_WAIT;
            r_rom_addr  <= '0;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_db    <= '0;
            r_init_done <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_long_wait <= 1'b0;
        end else begin
            case (r_state)
                PWR_WAIT: if (w_done) r_state <= FETCH;
                FETCH: begin
                    if (rom_rdy) begin
                        r_state     <= IDLE;
                        r_init_done <= 1'b1;
                        r_wr_ready  <= 1'b1;
                    end else begin
                        r_lcd_rs    <= w_rom_word.rs;
                        r_lcd_db    <= w_rom_word.data;
                        r_long_wait <= is_long_cmd(w_rom_word);
                        r_state     <= SETUP;
                    end
                end
                SETUP: if (w_done) begin
                    r_lcd_e <= 1'b1;
                    r_state <= E_HIGH;
                end
                E_HIGH: if (w_done) begin
                    r_lcd_e <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: if (w_done) begin
                    // The ROM has eight slots; the last one ends init even
                    // without an end flag, and the address never wraps.
                    if (r_init_done || (r_rom_addr == 3'd7)) begin
                        r_state     <= IDLE;
                        r_init_done <= 1'b1;
                        r_wr_ready  <= 1'b1;
                    end else begin
                        r_rom_addr <= r_rom_addr + 3'd1;
                        r_state    <= FETCH;
                    end
                end
                IDLE: if (w_accept) begin
                    r_lcd_rs    <= w_wr_word.rs;
                    r_lcd_db    <= w_wr_word.data;
                    r_long_wait <= is_long_cmd(w_wr_word);
                    r_wr_ready  <= 1'b0;
                    r_state     <= SETUP;
                end
                default: r_state <= PWR_WAIT;
            endcase
        end
    end

    assign rom_addr  = r_rom_addr;
    assign wr_ready  = r_wr_ready;
    assign init_done = r_init_done;
    assign lcd_rs    = r_lcd_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = r_lcd_e;
    assign lcd_db    = r_lcd_db;

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// Bench for lcd_init_ctrl: a cycle-indexed expected schedule built from the timing rules,
// checked every cycle, plus literal pins on pulse times, payloads and reset behaviour.
// Cycle k = k-th clock period after reset release; outputs sampled on the falling edge.
module tb_lcd_init_ctrl;

    localparam int PWR   = 10;
    localparam int SU    = 2;
    localparam int EH    = 3;
    localparam int CMD   = 5;
    localparam int CLR   = 20;
    localparam int DEPTH = 512;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rom_addr;
    logic [8:0] rom_q;
    logic       rom_rdy;
    logic       wr_valid;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    logic [8:0] rom_m [0:7];
    logic       rdy_m [0:7];

    assign rom_q   = rom_m[rom_addr];
    assign rom_rdy = rdy_m[rom_addr];

    lcd_init_ctrl #(
        .PWR_UP_CYC   (PWR),
        .SETUP_CYC    (SU),
        .E_HIGH_CYC   (EH),
        .CMD_WAIT_CYC (CMD),
        .CLR_WAIT_CYC (CLR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .rom_rdy   (rom_rdy),
        .wr_valid  (wr_valid),
        .wr_rs     (wr_rs),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .init_done (init_done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_db    (lcd_db)
    );

    always #5 clk = ~clk;

    int pcount = 0;
    int base   = 0;
    always @(posedge clk) pcount <= pcount + 1;

    int vectors     = 0;
    int miscompares = 0;

    // expected schedule
    bit         exp_e    [DEPTH];
    logic [8:0] exp_word [DEPTH];
    bit         exp_rdy  [DEPTH];
    bit         exp_done [DEPTH];
    int         init_idle;

    // observations from the compare process
    bit chk_en = 1'b0;
    int obs_rise [$];
    int obs_db   [$];
    int obs_rdy  [$];
    int done_cyc;
    bit prev_e, prev_rdy, prev_done;
    int cmp_k;

    function automatic int cur();
        return pcount - base;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cur(), got, exp);
        end
    endtask

    function automatic int q_at(input int q [$], input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i];
    endfunction

    function automatic int post_wait(input logic [8:0] w);
        return (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02)) ? CLR : CMD;
    endfunction

    task automatic plan_clear();
        for (int i = 0; i < DEPTH; i++) begin
            exp_e[i] = 0; exp_word[i] = '0; exp_rdy[i] = 0; exp_done[i] = 0;
        end
    endtask

    task automatic plan_pulse(input int rise, input logic [8:0] w);
        for (int i = rise; i < rise + EH; i++) begin
            exp_e[i] = 1; exp_word[i] = w;
        end
    endtask

    // Init: each ROM slot costs 1 fetch + SU setup + EH high + its wait.
    task automatic plan_init(output int idle_at);
        int t, rise;
        bit fin;
        t = PWR; idle_at = DEPTH; fin = 0;
        for (int a = 0; a < 8 && !fin; a++) begin
            if (rdy_m[a]) begin
                idle_at = t + 1; fin = 1;
            end else begin
                rise = t + 1 + SU;
                plan_pulse(rise, rom_m[a]);
                t = rise + EH + post_wait(rom_m[a]);
                if (a == 7) idle_at = t;
            end
        end
        for (int i = idle_at; i < DEPTH; i++) begin
            exp_rdy[i] = 1; exp_done[i] = 1;
        end
    endtask

    // User write accepted at the end of cycle a.
    task automatic plan_write(input int a, input logic [8:0] w, output int back);
        int rise;
        rise = a + 1 + SU;
        plan_pulse(rise, w);
        back = rise + EH + post_wait(w);
        for (int i = a + 1; i < back; i++) exp_rdy[i] = 0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_k = cur();
            if (cmp_k < DEPTH) begin
                check("lcd_e", int'(lcd_e), int'(exp_e[cmp_k]));
                check("wr_ready", int'(wr_ready), int'(exp_rdy[cmp_k]));
                check("init_done", int'(init_done), int'(exp_done[cmp_k]));
                check("lcd_rw", int'(lcd_rw), 0);
                if (exp_e[cmp_k]) begin
                    check("lcd_rs", int'(lcd_rs), int'(exp_word[cmp_k][8]));
                    check("lcd_db", int'(lcd_db), int'(exp_word[cmp_k][7:0]));
                end
            end
            if (lcd_e && !prev_e) begin
                obs_rise.push_back(cmp_k);
                obs_db.push_back(int'(lcd_db));
            end
            if (wr_ready && !prev_rdy) obs_rdy.push_back(cmp_k);
            if (init_done && !prev_done) done_cyc = cmp_k;
            prev_e = lcd_e; prev_rdy = wr_ready; prev_done = init_done;
        end
    end

    task automatic start_run();
        int idle;
        plan_clear();
        plan_init(idle);
        init_idle = idle;
        obs_rise.delete(); obs_db.delete(); obs_rdy.delete();
        done_cyc = -1; prev_e = 0; prev_rdy = 0; prev_done = 0;
        @(negedge clk); #1;
        rst = 1'b0; base = pcount; chk_en = 1'b1;
    endtask

    task automatic goto(input int k);
        while (cur() < k) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_e"}, int'(lcd_e), 0);
        check({tag, "_rs"}, int'(lcd_rs), 0);
        check({tag, "_db"}, int'(lcd_db), 0);
        check({tag, "_rw"}, int'(lcd_rw), 0);
        check({tag, "_done"}, int'(init_done), 0);
        check({tag, "_rdy"}, int'(wr_ready), 0);
        check({tag, "_addr"}, int'(rom_addr), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cur());
        $fatal(1, "watchdog");
    end

    int rise_lit [4];
    int db_lit   [4];
    int a, b, back;

    initial begin
        rise_lit = '{13, 24, 35, 61};
        db_lit   = '{'h3C, 'h06, 'h01, 'h0F};
        rom_m = '{9'h03C, 9'h006, 9'h001, 9'h00F, 9'h000, 9'h000, 9'h000, 9'h000};
        rdy_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        wr_valid = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("por");

        // Power-up ROM walk
        start_run();
        goto(init_idle + 2);
        check("init_pulses", obs_rise.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("init_rise", q_at(obs_rise, i), rise_lit[i]);
            check("init_db", q_at(obs_db, i), db_lit[i]);
        end
        check("init_done_cyc", done_cyc, 70);
        check("init_ready_cyc", q_at(obs_rdy, 0), 70);
        check("init_addr", int'(rom_addr), 4);

        // Data write 'A'
        a = cur();
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h41;
        plan_write(a, 9'h141, back);
        goto(a + 1);
        wr_valid = 1'b0;
        check("w1_rdy_low", int'(wr_ready), 0);
        check("w1_rs", int'(lcd_rs), 1);
        check("w1_db", int'(lcd_db), 'h41);
        goto(back + 2);
        check("w1_rise_ofs", q_at(obs_rise, 4) - a, 3);
        check("w1_ready_ofs", q_at(obs_rdy, 1) - a, 11);

        // Home command with wr_valid held through the transfer
        b = cur();
        wr_valid = 1'b1; wr_rs = 1'b0; wr_data = 8'h02;
        plan_write(b, 9'h002, back);
        goto(back - 1);
        wr_valid = 1'b0;
        goto(back + 3);
        check("w2_pulses", obs_rise.size(), 6);
        check("w2_ready_ofs", q_at(obs_rdy, 2) - b, 26);

        // Reset in the middle of the second init E pulse
        rst = 1'b1; chk_en = 1'b0;
        repeat (2) @(negedge clk);
        start_run();
        goto(25);
        check("mid_e_live", int'(lcd_e), 1);
        rst = 1'b1; chk_en = 1'b0;
        #1;
        check_reset_vals("mid");
        repeat (3) @(negedge clk);
        start_run();
        goto(init_idle + 2);
        check("replay_rise0", q_at(obs_rise, 0), 13);
        check("replay_db0", q_at(obs_db, 0), 'h3C);
        check("replay_pulses", obs_rise.size(), 4);

        // ROM without an end flag: stops after slot 7
        rst = 1'b1; chk_en = 1'b0;
        rom_m = '{9'h030, 9'h101, 9'h102, 9'h038, 9'h00C, 9'h080, 9'h0C0, 9'h155};
        rdy_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        repeat (2) @(negedge clk);
        start_run();
        goto(init_idle + 3);
        check("full_pulses", obs_rise.size(), 8);
        check("full_addr", int'(rom_addr), 7);
        check("full_done", int'(init_done), 1);
        check("full_done_cyc", done_cyc, 98);
        check("full_last_db", q_at(obs_db, 7), 'h55);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
